debounce_multi: RTL
===================

// Module: debounce_multi
// PURPOSE
//  N-channel pushbutton/switch debouncer with shared tick prescaler; next generation of single-channel debounce.
//  Per channel: 2-flop synchroniser, tick-driven stability counter, debounced level plus press/release strobes.
//  Sits between raw board inputs (buttons, DIP switches) and MCS-51 port/IRQ logic; one instance serves a bank.
// PARAMETERS
//  CHANNELS     4      number of independent input channels (1..32)
//  ACTIVE_LOW   1      1: raw input low = pressed (inverted at first sync flop); 0: high = pressed
//  TICK_DIV     1024   CLK cycles per debounce tick (>=1); shared prescaler
//  DELAY_TICKS  16     consecutive stable ticks required before PB_state toggles (>=2)
//  REPEAT_START 64     ticks held before first auto-repeat strobe (DEBOUNCE_REPEAT_EN only)
//  REPEAT_RATE  8      ticks between subsequent repeat strobes (DEBOUNCE_REPEAT_EN only)
// PORTS
//  CLK        in   1         single clock, all logic posedge
//  RST_N      in   1         asynchronous, active-low reset
//  PB         in   CHANNELS  raw asynchronous inputs
//  PB_state   out  CHANNELS  debounced level, 1 = pressed
//  PB_down    out  CHANNELS  1-CLK strobe on debounced press (and auto-repeat if enabled)
//  PB_up      out  CHANNELS  1-CLK strobe on debounced release
//  TICK       out  1         1-CLK prescaler strobe, for bench/other blocks
// BEHAVIOUR
//  - Reset (RST_N low, async): sync flops = released, PB_state=0, PB_down=PB_up=0, counters=0, prescaler=0, TICK=0.
//  - Prescaler: counts 0..TICK_DIV-1, TICK=1 in the cycle it wraps; TICK_DIV=1 -> TICK every cycle.
//  - Sync: pressed-normalised s1 = two flops after polarity fix; input-to-s1 latency 2 CLK.
//  - Per channel: idle = (s1 == PB_state). idle -> cnt<=0 immediately (any CLK, not only TICK).
//    !idle & TICK -> cnt<=cnt+1; !idle & TICK & cnt==DELAY_TICKS-1 -> PB_state toggles, cnt<=0.
//  - PB_down/PB_up asserted in the same CLK that the toggle is registered (combinational from toggle condition,
//    like prior block); PB_down when rising to 1, PB_up when falling to 0. Never both in one cycle per channel.
//  - Glitch shorter than one full stable run restarts count; no toggle. Total latency press->PB_down:
//    2 CLK + (DELAY_TICKS-1)*TICK_DIV + phase-to-first-tick (0..TICK_DIV-1) CLK.
//  - Counter width $clog2(DELAY_TICKS); never wraps (cleared at terminal). Channels fully independent;
//    simultaneous events on several channels produce simultaneous strobes.
//  - Reset mid-count: all state discarded; after release, a held button produces a fresh full debounce then PB_down.
// CONFIGURATION
//  DEBOUNCE_REPEAT_EN defined: while PB_state=1, per-channel hold counter counts TICKs; PB_down re-strobes
//   after REPEAT_START ticks, then every REPEAT_RATE ticks; release or reset clears hold counter; PB_up unaffected.
//  Not defined: no hold counters synthesised; PB_down only on debounced press; REPEAT_* ignored.
// STRUCTURE
//  debounce_pkg: DEBOUNCE_CNT_W/HOLD_W width helpers (clog2), polarity constants, default parameter values.
//  Sub-module debounce_chan (one per channel, generate loop): sync flops, stability counter, state, strobes,
//   optional hold counter. Top holds prescaler only and fans TICK to all channels.
// TESTING  (CHANNELS=4, ACTIVE_LOW=1, TICK_DIV=4, DELAY_TICKS=8, REPEAT_START=16, REPEAT_RATE=4)
//  1 Reset: RST_N=0 with PB=4'hF then 4'h0 -> PB_state=0, strobes 0, TICK=0 throughout; async assertion mid-cycle.
//  2 Clean press ch0: PB[0] 1->0, hold -> PB_down[0] single pulse 30..33 CLK later, PB_state[0]=1 same edge.
//  3 Bounce ch1: PB[1] toggles every 5 CLK for 60 CLK then settles low -> no strobe during bounce;
//    exactly one PB_down[1] after settling + debounce latency.
//  4 Release ch0 after 2: PB[0] 0->1 -> one PB_up[0] after 30..33 CLK, PB_state[0]=0; no PB_down.
//  5 Simultaneous ch2,ch3 press same cycle -> PB_down[2] and PB_down[3] in same CLK; ch0/1 quiet.
//  6 Reset mid-count: press ch0, drop RST_N at CLK 20 for 3 CLK -> no strobe; full latency restarts after release.
//  7 (DEBOUNCE_REPEAT_EN) hold ch0 200 CLK -> PB_down at debounce, again 64 CLK later, then every 16 CLK.

Source files
------------

// File: rtl/debounce_multi_pkg.sv
// debounce_pkg: width helpers, polarity constants and defaults.
// Auto-repeat hardware is built only when DEBOUNCE_REPEAT_EN is defined.
package debounce_pkg;

  localparam bit POL_ACTIVE_LOW  = 1'b1;
  localparam bit POL_ACTIVE_HIGH = 1'b0;

  localparam int DEF_CHANNELS     = 4;
  localparam bit DEF_ACTIVE_LOW   = POL_ACTIVE_LOW;
  localparam int DEF_TICK_DIV     = 1024;
  localparam int DEF_DELAY_TICKS  = 16;
  localparam int DEF_REPEAT_START = 64;
  localparam int DEF_REPEAT_RATE  = 8;

  typedef struct packed {
    logic down;
    logic up;
  } dbc_evt_t;

  function automatic int debounce_w(
    input int n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int DEBOUNCE_CNT_W(
    input int delay_ticks
  );
    return debounce_w(delay_ticks);
  endfunction

  function automatic int DEBOUNCE_HOLD_W(
    input int repeat_start
  );
    return debounce_w(repeat_start);
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// debounce_multi_if: raw inputs and debounced outputs of one bank.
// master drives the raw buttons, slave is the debouncer.
interface debounce_multi_if #(
  parameter int CHANNELS = 4
);

  logic [CHANNELS-1:0] PB;
  logic [CHANNELS-1:0] PB_state;
  logic [CHANNELS-1:0] PB_down;
  logic [CHANNELS-1:0] PB_up;
  logic                TICK;

  modport master (
    output PB,
    input  PB_state,
    input  PB_down,
    input  PB_up,
    input  TICK
  );

  modport slave (
    input  PB,
    output PB_state,
    output PB_down,
    output PB_up,
    output TICK
  );

endinterface

// File: rtl/debounce_multi_chan.sv
// debounce_chan: one channel - synchroniser, stability counter, strobes.
// Hold counter for auto-repeat exists only under DEBOUNCE_REPEAT_EN.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter bit ACTIVE_LOW   = DEF_ACTIVE_LOW,
  parameter int DELAY_TICKS  = DEF_DELAY_TICKS,
  parameter int REPEAT_START = DEF_REPEAT_START,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_tick,
  input  logic     i_pb,
  output logic     o_state,
  output dbc_evt_t o_evt
);

  localparam int CW = DEBOUNCE_CNT_W(DELAY_TICKS);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DELAY_TICKS - 1);

  logic          r_s0;
  logic          r_s1;
  logic          r_state;
  logic [CW-1:0] r_cnt;
  logic          w_idle;
  logic          w_toggle;
  logic          w_rep;

  // s0/s1 hold the pressed-normalised level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      r_s0 <= i_pb ^ ACTIVE_LOW;
      r_s1 <= r_s0;
    end
  end

  assign w_idle   = (r_s1 == r_state);
  assign w_toggle = !w_idle && i_tick &&
                    (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_state <= 1'b0;
    end else begin
      if (w_idle || w_toggle) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_toggle) begin
        r_state <= ~r_state;
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int HW = DEBOUNCE_HOLD_W(REPEAT_START);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(REPEAT_START - 1);
  localparam logic [HW-1:0] HOLD_RELOAD =
    HW'(REPEAT_START - REPEAT_RATE);

  logic [HW-1:0] r_hold;

  // reload so the next strobe lands REPEAT_RATE ticks later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (!r_state || w_toggle) begin
      r_hold <= '0;
    end else if (i_tick) begin
      if (r_hold == HOLD_LAST) begin
        r_hold <= HOLD_RELOAD;
      end else begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  assign w_rep = r_state && i_tick && !w_toggle &&
                 (r_hold == HOLD_LAST);
`else
  logic w_unused_rpt;
  assign w_unused_rpt = ^{32'(REPEAT_START),
                          32'(REPEAT_RATE)};
  assign w_rep = 1'b0;
`endif

  assign o_state    = r_state;
  assign o_evt.down = (w_toggle && !r_state) || w_rep;
  assign o_evt.up   = w_toggle && r_state;

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: N-channel debouncer with a shared tick prescaler.
// Define DEBOUNCE_REPEAT_EN to add per-channel PB_down auto-repeat.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter bit ACTIVE_LOW   = DEF_ACTIVE_LOW,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int DELAY_TICKS  = DEF_DELAY_TICKS,
  parameter int REPEAT_START = DEF_REPEAT_START,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input logic             CLK,
  input logic             RST_N,
  debounce_multi_if.slave bus
);

  localparam int DW = debounce_w(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST =
    DW'(TICK_DIV - 1);

  logic [DW-1:0]       r_div;
  logic                r_run;
  logic                w_tick;
  logic [CHANNELS-1:0] w_state;
  logic [CHANNELS-1:0] w_down;
  logic [CHANNELS-1:0] w_up;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_div <= '0;
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_div == DIV_LAST) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  // r_run keeps TICK low in reset even when TICK_DIV is 1
  assign w_tick = r_run && (r_div == DIV_LAST);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    dbc_evt_t w_evt;

    debounce_chan #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .DELAY_TICKS  (DELAY_TICKS),
      .REPEAT_START (REPEAT_START),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_chan (
      .clk     (CLK),
      .rst_n   (RST_N),
      .i_tick  (w_tick),
      .i_pb    (bus.PB[g]),
      .o_state (w_state[g]),
      .o_evt   (w_evt)
    );

    assign w_down[g] = w_evt.down;
    assign w_up[g]   = w_evt.up;
  end

  assign bus.PB_state = w_state;
  assign bus.PB_down  = w_down;
  assign bus.PB_up    = w_up;
  assign bus.TICK     = w_tick;

endmodule
